mem_wb: RTL
===========

# mem_wb

Pipeline register and load-completion stage between the MEM stage and the register file write port. It captures MEM-stage results, aligns and sign- or zero-extends load data from the data memory, and drives the regfile write interface (`we`/`waddr`/`wdata`). When load data arrives late, it holds the pipeline with a stall request.

## Interface
- `LOAD_TYPE_W`, default 3: width of the load-type code.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_wreg` input 1: MEM-stage register write enable.
- `mem_wd` input 5: MEM-stage destination register address.
- `mem_wdata` input 32: MEM-stage ALU/result data (non-load).
- `mem_load` input 3: load type. 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none.
- `mem_addr_lo` input 2: low two bits of the load address.
- `mem_rdata` input 32: data-memory read word, little-endian.
- `mem_rvalid` input 1: `mem_rdata` is valid this cycle.
- `stall_mem` input 1: MEM stage is stalled this cycle.
- `stall_wb` input 1: this stage is held this cycle.
- `flush` input 1: discard the stage contents.
- `wb_we` output 1: regfile write enable.
- `wb_waddr` output 5: regfile write address.
- `wb_wdata` output 32: regfile write data.
- `stall_req` output 1: combinational request to stall the pipeline.
- `misalign_exc` output 1: misaligned-load pulse (only when the configuration macro is defined; see Configuration).

## Operation
- States: IDLE and LOAD_WAIT.
- Advance condition (IDLE only): `!stall_mem && !stall_wb && !flush`.
- **IDLE, advance, `mem_load` = none:** `wb_we`/`wb_waddr`/`wb_wdata` <= `mem_wreg`/`mem_wd`/`mem_wdata`.
- **IDLE, advance, load, `mem_rvalid` = 1:** `wb_wdata` <= ext(`mem_rdata`); `wb_we` <= `mem_wreg`; `wb_waddr` <= `mem_wd`.
- **IDLE, advance, load, `mem_rvalid` = 0:**
  - Save `mem_wreg`, `mem_wd`, `mem_load`, `mem_addr_lo`.
  - `wb_we` <= 0; go to LOAD_WAIT.
- **IDLE, `stall_mem && !stall_wb`:** bubble. `wb_we` <= 0; address and data hold.
- **IDLE, `stall_wb`:** all outputs hold.
- **LOAD_WAIT:**
  - `stall_req` = 1 and `wb_we` = 0.
  - MEM inputs other than `mem_rdata`/`mem_rvalid` are ignored.
  - When `mem_rvalid` = 1: drive the saved `wb_we`/`wb_waddr`, set `wb_wdata` <= ext(`mem_rdata`), and return to IDLE.
  - `stall_wb` does not delay load completion.
- **`flush` (any state, priority over everything except `rst`):** `wb_we` <= 0; state <= IDLE; saved load is discarded.
- **Extraction** (byte lane = `addr_lo`):
  - LB/LBU: byte `addr_lo`.
  - LH/LHU: halfword `addr_lo[1]`.
  - LW: the full word.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- `wb_waddr` = 0 is passed through unchanged; the regfile drops writes to r0.

## Timing
- Reset values (asynchronous, immediate): `wb_we` = 0, `wb_waddr` = 0, `wb_wdata` = 0x00000000, state IDLE, `stall_req` = 0, `misalign_exc` = 0.
- Latency:
  - Non-load: 1 cycle, MEM input to `wb_*` output.
  - Load with data ready: 1 cycle.
  - Late load: 1 cycle after the first `mem_rvalid` edge in LOAD_WAIT.
- `stall_req` is combinational from state only: high exactly while in LOAD_WAIT, with no input-to-output path.
- `wb_we` is high for one cycle per retired instruction, unless `stall_wb` holds it.
- `mem_rvalid` while in IDLE with no load advancing: ignored.
- `rst` asserted in LOAD_WAIT: returns to IDLE and drops `stall_req` immediately.

## Configuration
- Macro: `MEM_WB_MISALIGN_CHECK_EN`.
- **Defined:** adds output `misalign_exc`, 1 bit.
  - A load is misaligned when it is LH/LHU with `addr_lo[0]` = 1, or LW with `addr_lo` ≠ 00.
  - On retirement of a misaligned load, `wb_we` is forced to 0 and `misalign_exc` pulses high for the same cycle.
  - This applies to both the immediate and the LOAD_WAIT completion paths.
  - Reset value of `misalign_exc` is 0.
- **Undefined:** no `misalign_exc` port.
  - LW ignores `addr_lo`.
  - LH/LHU use only `addr_lo[1]`.
  - The write always occurs.

## Test plan
- **Reset mid-LOAD_WAIT:** assert `rst` asynchronously -> `stall_req` = 0 and all `wb_*` = 0 before the next edge.
- **ALU result, no stalls:** `mem_wreg` = 1, `mem_wd` = 5, `mem_wdata` = 0x12345678 -> next cycle `wb_we` = 1, `wb_waddr` = 5, `wb_wdata` = 0x12345678.
- **LB vs LBU, data ready:** `mem_rdata` = 0x80FF7F01.
  - LB, `addr_lo` = 3 -> `wb_wdata` = 0xFFFFFF80.
  - LBU, `addr_lo` = 3 -> `wb_wdata` = 0x00000080.
  - LH, `addr_lo` = 2 -> `wb_wdata` = 0xFFFF80FF.
- **Late LW:** `mem_rvalid` = 0 for 3 cycles, then 0xDEADBEEF -> `stall_req` high for 3 cycles, `wb_we` = 0 during the wait, then one cycle with `wb_we` = 1 and `wb_wdata` = 0xDEADBEEF.
- **Stall/flush:**
  - `stall_mem` = 1, `stall_wb` = 0 -> bubble (`wb_we` = 0).
  - `stall_wb` = 1 -> outputs hold.
  - `flush` in LOAD_WAIT -> IDLE; a later `mem_rvalid` produces no write.
- **With `MEM_WB_MISALIGN_CHECK_EN` defined:** LW with `addr_lo` = 2 -> `misalign_exc` = 1 for 1 cycle, `wb_we` = 0. Without the macro, the same stimulus writes `mem_rdata` unchanged.

Source files
------------

// File: rtl/mem_wb.sv
// MEM/WB pipeline register with load alignment/extension and late-load stall.
// Optional misaligned-load detection is enabled by defining MEM_WB_MISALIGN_CHECK_EN.
module mem_wb #(
  parameter int LOAD_TYPE_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_wreg,
  input  logic [4:0]             mem_wd,
  input  logic [31:0]            mem_wdata,
  input  logic [LOAD_TYPE_W-1:0] mem_load,
  input  logic [1:0]             mem_addr_lo,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_rvalid,
  input  logic                   stall_mem,
  input  logic                   stall_wb,
  input  logic                   flush,
  output logic                   wb_we,
  output logic [4:0]             wb_waddr,
  output logic [31:0]            wb_wdata,
  output logic                   stall_req
`ifdef MEM_WB_MISALIGN_CHECK_EN
  ,
  output logic                   misalign_exc
`endif
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  typedef enum logic [LOAD_TYPE_W-1:0] {
    LD_NONE = LOAD_TYPE_W'(0),
    LD_LB   = LOAD_TYPE_W'(1),
    LD_LH   = LOAD_TYPE_W'(2),
    LD_LW   = LOAD_TYPE_W'(3),
    LD_LBU  = LOAD_TYPE_W'(4),
    LD_LHU  = LOAD_TYPE_W'(5)
  } ld_t;

  state_t      state, state_n;
  logic        we_n;
  logic [4:0]  waddr_n;
  logic [31:0] wdata_n;

  logic        sv_wreg, sv_wreg_n;
  logic [4:0]  sv_wd, sv_wd_n;
  ld_t         sv_load, sv_load_n;
  logic [1:0]  sv_lo, sv_lo_n;

  ld_t         sel_load;
  logic [1:0]  sel_lo;
  logic        sel_wreg;
  logic [4:0]  sel_wd;
  logic        is_load;
  logic        mis;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;

`ifdef MEM_WB_MISALIGN_CHECK_EN
  logic        exc_n;
`endif

  assign stall_req = (state == LOAD_WAIT);

  // In LOAD_WAIT the saved load descriptor drives extraction; the live MEM inputs are ignored.
  always_comb begin
    sel_load = (state == LOAD_WAIT) ? sv_load : ld_t'(mem_load);
    sel_lo   = (state == LOAD_WAIT) ? sv_lo   : mem_addr_lo;
    sel_wreg = (state == LOAD_WAIT) ? sv_wreg : mem_wreg;
    sel_wd   = (state == LOAD_WAIT) ? sv_wd   : mem_wd;
    is_load  = sel_load inside {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU};

    case (sel_lo)
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = sel_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (sel_load)
      LD_LB:   ld_data = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  ld_data = {24'h0, byte_v};
      LD_LH:   ld_data = {{16{half_v[15]}}, half_v};
      LD_LHU:  ld_data = {16'h0, half_v};
      default: ld_data = mem_rdata;
    endcase

`ifdef MEM_WB_MISALIGN_CHECK_EN
    mis = ((sel_load inside {LD_LH, LD_LHU}) && sel_lo[0]) ||
          ((sel_load == LD_LW) && (sel_lo != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  always_comb begin
    state_n   = state;
    we_n      = wb_we;
    waddr_n   = wb_waddr;
    wdata_n   = wb_wdata;
    sv_wreg_n = sv_wreg;
    sv_wd_n   = sv_wd;
    sv_load_n = sv_load;
    sv_lo_n   = sv_lo;
`ifdef MEM_WB_MISALIGN_CHECK_EN
    exc_n     = 1'b0;
`endif

    if (flush) begin
      state_n = IDLE;
      we_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (stall_wb) begin
`ifdef MEM_WB_MISALIGN_CHECK_EN
            exc_n = misalign_exc;
`endif
          end else if (stall_mem) begin
            we_n = 1'b0;
          end else if (!is_load) begin
            we_n    = mem_wreg;
            waddr_n = mem_wd;
            wdata_n = mem_wdata;
          end else if (mem_rvalid) begin
            we_n    = sel_wreg & ~mis;
            waddr_n = sel_wd;
            wdata_n = ld_data;
`ifdef MEM_WB_MISALIGN_CHECK_EN
            exc_n   = mis;
`endif
          end else begin
            sv_wreg_n = mem_wreg;
            sv_wd_n   = mem_wd;
            sv_load_n = sel_load;
            sv_lo_n   = mem_addr_lo;
            we_n      = 1'b0;
            state_n   = LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          we_n = 1'b0;
          if (mem_rvalid) begin
            we_n    = sel_wreg & ~mis;
            waddr_n = sel_wd;
            wdata_n = ld_data;
`ifdef MEM_WB_MISALIGN_CHECK_EN
            exc_n   = mis;
`endif
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      sv_wreg  <= 1'b0;
      sv_wd    <= '0;
      sv_load  <= LD_NONE;
      sv_lo    <= '0;
`ifdef MEM_WB_MISALIGN_CHECK_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      wb_we    <= we_n;
      wb_waddr <= waddr_n;
      wb_wdata <= wdata_n;
      sv_wreg  <= sv_wreg_n;
      sv_wd    <= sv_wd_n;
      sv_load  <= sv_load_n;
      sv_lo    <= sv_lo_n;
`ifdef MEM_WB_MISALIGN_CHECK_EN
      misalign_exc <= exc_n;
`endif
    end
  end

endmodule
